// File: rtl/nios_ii_video_pkg.sv
// Shared width defaults and reader state encoding for the video DMA blocks.
package nios_ii_video_pkg;

  localparam int unsigned ADDR_W_DEF     = 15;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/onchip_mem_reader_fifo.sv
// Synchronous show-ahead FIFO: head word visible on rdata whenever not empty.
module onchip_mem_reader_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    pop,
  output logic [DATA_W-1:0]       rdata,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  cnt;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/onchip_mem_reader.sv
// Reads word_count words from an Avalon-MM slave starting at base_addr and
// streams them out an Avalon-ST source with sop/eop framing.
module onchip_mem_reader
  import nios_ii_video_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_W-1:0]     src_data,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic                  src_sop,
  output logic                  src_eop
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                read_nxt;
  logic                done_nxt;
  logic [ADDR_W-1:0]   req_left;
  logic [ADDR_W-1:0]   req_left_nxt;
  logic [ADDR_W-1:0]   out_idx;
  logic [ADDR_W-1:0]   out_idx_nxt;
  logic [ADDR_W-1:0]   total;
  logic [ADDR_W-1:0]   total_nxt;
  logic [CNT_W-1:0]    pending;
  logic [CNT_W-1:0]    pending_nxt;
  logic [CNT_W-1:0]    level;
  logic [CNT_W-1:0]    level_nxt;
  logic                accept;
  logic                push;
  logic                pop;
  logic                credit_ok;
  logic                last_word;
  logic                fifo_empty;

  assign accept    = avm_read & ~avm_waitrequest;
  // Returned data only counts while a transfer is live; stragglers after reset are dropped.
  assign push      = avm_readdatavalid & (state != ST_IDLE);
  assign pop       = src_valid & src_ready;
  assign last_word = (out_idx == total - ADDR_W'(1));

  assign pending_nxt = pending + CNT_W'(accept) - CNT_W'(push);
  assign level_nxt   = level + CNT_W'(push) - CNT_W'(pop);
  // Every outstanding read must have a guaranteed FIFO slot when its data returns.
  assign credit_ok   = (SUM_W'(pending_nxt) + SUM_W'(level_nxt)) < SUM_W'(FIFO_DEPTH);

  assign busy           = (state != ST_IDLE);
  assign avm_byteenable = '1;
  assign src_valid      = ~fifo_empty;
  assign src_sop        = src_valid & (out_idx == '0);
  assign src_eop        = src_valid & last_word;

  onchip_mem_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wdata  (avm_readdata),
    .pop    (pop),
    .rdata  (src_data),
    .empty  (fifo_empty),
    .level  (level)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      avm_address <= '0;
      avm_read    <= 1'b0;
      done        <= 1'b0;
      req_left    <= '0;
      out_idx     <= '0;
      total       <= '0;
      pending     <= '0;
    end else begin
      state       <= state_nxt;
      avm_address <= addr_nxt;
      avm_read    <= read_nxt;
      done        <= done_nxt;
      req_left    <= req_left_nxt;
      out_idx     <= out_idx_nxt;
      total       <= total_nxt;
      pending     <= pending_nxt;
    end
  end

  // Next-state and request generation.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = avm_address;
    read_nxt     = avm_read;
    req_left_nxt = req_left;
    out_idx_nxt  = out_idx;
    total_nxt    = total;
    done_nxt     = 1'b0;

    if (pop) out_idx_nxt = out_idx + ADDR_W'(1);

    unique case (state)
      ST_IDLE: begin
        read_nxt = 1'b0;
        if (start) begin
          if (word_count != '0) begin
            state_nxt    = ST_READ;
            addr_nxt     = base_addr;
            req_left_nxt = word_count;
            total_nxt    = word_count;
            out_idx_nxt  = '0;
            read_nxt     = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (accept) begin
          addr_nxt     = avm_address + ADDR_W'(1);
          req_left_nxt = req_left - ADDR_W'(1);
          if (req_left == ADDR_W'(1)) begin
            state_nxt = ST_DRAIN;
            read_nxt  = 1'b0;
          end else begin
            read_nxt = credit_ok;
          end
        end else if (!avm_read) begin
          read_nxt = credit_ok;
        end
      end

      ST_DRAIN: begin
        read_nxt = 1'b0;
        if (pop && last_word) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        read_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_onchip_mem_reader.sv
// Directed bench for onchip_mem_reader: Avalon-MM slave model with settable
// latency/stall, and a scoreboard of expected addresses and stream words.
module tb_onchip_mem_reader;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_count = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest = 1'b0;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready = 1'b1;
  logic              src_sop;
  logic              src_eop;

  onchip_mem_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_sop           (src_sop),
    .src_eop           (src_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } word_t;

  typedef struct {
    logic [ADDR_W-1:0] a;
    int                due;
  } rsp_t;

  word_t             exp_words[$];
  logic [ADDR_W-1:0] exp_addr[$];
  rsp_t              rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_due = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int lat_fix  = 1;
  bit lat_rand = 1'b0;
  bit acc_flag = 1'b0;
  logic [ADDR_W-1:0] acc_a = '0;
  bit                prev_avm_hold = 1'b0;
  bit                prev_src_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], 8'h5A, 1'b0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    word_t w;
    if (avm_read && !avm_waitrequest) begin
      acc_flag = 1'b1;
      acc_a    = avm_address;
      n_acc++;
      if (!reset) begin
        if (exp_addr.size() == 0) chk("unexpected_read", 1, 0);
        else chk("read_addr", avm_address, exp_addr.pop_front());
      end
    end
    if (!reset) begin
      if (prev_avm_hold) begin
        chk("avm_hold_read", avm_read, 1);
        chk("avm_hold_addr", avm_address, prev_addr);
      end
      if (prev_src_hold) begin
        chk("src_hold_valid", src_valid, 1);
        chk("src_hold_data", src_data, prev_data);
      end
      if (avm_read && avm_waitrequest) stall_cnt++;
      if (src_valid && src_ready) begin
        n_pop++;
        if (exp_words.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          w = exp_words.pop_front();
          chk("src_data", src_data, w.data);
          chk("src_sop", src_sop, w.sop);
          chk("src_eop", src_eop, w.eop);
        end
      end
      if (done) done_cnt++;
    end
    prev_avm_hold = !reset && avm_read && avm_waitrequest;
    prev_addr     = avm_address;
    prev_src_hold = !reset && src_valid && !src_ready;
    prev_data     = src_data;
  end

  // Slave model: in-order responses, latency fixed or random 1..3 cycles.
  always begin : slave
    rsp_t r;
    int   lat;
    @(posedge clk);
    cyc++;
    if (acc_flag) begin
      lat   = lat_rand ? int'($urandom_range(3, 1)) : lat_fix;
      r.a   = acc_a;
      r.due = cyc + lat - 1;
      if (r.due < last_due) r.due = last_due;
      last_due = r.due;
      rsp_q.push_back(r);
      acc_flag = 1'b0;
    end
    #1;
    if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(rsp_q[0].a);
      void'(rsp_q.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_acc     = 0;
    n_pop     = 0;
    done_cnt  = 0;
    stall_cnt = 0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    step();
    start = 1'b0;
  endtask

  task automatic expect_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
    logic [ADDR_W-1:0] a;
    word_t w;
    for (int i = 0; i < int'(c); i++) begin
      a      = b + ADDR_W'(i);
      w.data = mem_word(a);
      w.sop  = (i == 0);
      w.eop  = (i == int'(c) - 1);
      exp_addr.push_back(a);
      exp_words.push_back(w);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      step();
    end
    chk("done_seen", done_cnt > 0, 1);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_src_valid", src_valid, 0);
    chk("rst_src_sop", src_sop, 0);
    chk("rst_src_eop", src_eop, 0);
    chk("byteenable", avm_byteenable, 4'hF);

    // Basic 4-word read, latency 1, no stalls.
    step();
    clear_stats();
    lat_fix = 1;
    expect_xfer(15'h0010, 15'd4);
    pulse_start(15'h0010, 15'd4);
    wait_done(40);
    repeat (3) step();
    chk("t1_done_once", done_cnt, 1);
    chk("t1_reads", n_acc, 4);
    chk("t1_words", n_pop, 4);
    chk("t1_busy", busy, 0);

    // Waitrequest held for 3 cycles on the second request.
    step();
    clear_stats();
    expect_xfer(15'h0010, 15'd4);
    pulse_start(15'h0010, 15'd4);
    for (int i = 0; i < 20; i++) begin
      if (n_acc >= 1) break;
      step();
    end
    avm_waitrequest = 1'b1;
    repeat (3) step();
    avm_waitrequest = 1'b0;
    wait_done(40);
    repeat (3) step();
    chk("t2_stall_cycles", stall_cnt, 3);
    chk("t2_reads", n_acc, 4);
    chk("t2_words", n_pop, 4);
    chk("t2_done_once", done_cnt, 1);

    // Backpressure: only FIFO_DEPTH reads may be in flight.
    step();
    clear_stats();
    src_ready = 1'b0;
    expect_xfer(15'h0200, 15'd40);
    pulse_start(15'h0200, 15'd40);
    repeat (60) step();
    chk("t3_reads_capped", n_acc, 16);
    chk("t3_avm_read_off", avm_read, 0);
    chk("t3_head_valid", src_valid, 1);
    chk("t3_head_data", src_data, mem_word(15'h0200));
    chk("t3_head_sop", src_sop, 1);
    lat_rand  = 1'b1;
    src_ready = 1'b1;
    wait_done(400);
    repeat (3) step();
    lat_rand = 1'b0;
    chk("t3_reads", n_acc, 40);
    chk("t3_words", n_pop, 40);
    chk("t3_done_once", done_cnt, 1);

    // Address wrap at the top of the word space.
    step();
    clear_stats();
    expect_xfer(15'h7FFE, 15'd4);
    pulse_start(15'h7FFE, 15'd4);
    wait_done(40);
    repeat (3) step();
    chk("t4_words", n_pop, 4);
    chk("t4_done_once", done_cnt, 1);

    // Zero-length request: immediate done, no bus activity.
    step();
    clear_stats();
    pulse_start(15'h0055, 15'd0);
    @(negedge clk);
    chk("t5_done_pulse", done, 1);
    chk("t5_busy", busy, 0);
    step();
    @(negedge clk);
    chk("t5_done_low", done, 0);
    chk("t5_no_reads", n_acc, 0);
    chk("t5_done_once", done_cnt, 1);

    // Start while busy is ignored.
    step();
    clear_stats();
    lat_fix = 3;
    expect_xfer(15'h0300, 15'd4);
    pulse_start(15'h0300, 15'd4);
    pulse_start(15'h0400, 15'd8);
    step();
    pulse_start(15'h0500, 15'd2);
    wait_done(60);
    repeat (5) step();
    chk("t6_done_once", done_cnt, 1);
    chk("t6_reads", n_acc, 4);
    chk("t6_words", n_pop, 4);
    chk("t6_busy", busy, 0);

    // Reset mid-READ with two reads outstanding.
    step();
    clear_stats();
    lat_fix = 6;
    expect_xfer(15'h0100, 15'd8);
    pulse_start(15'h0100, 15'd8);
    for (int i = 0; i < 20; i++) begin
      if (n_acc >= 2) break;
      step();
    end
    chk("t7_two_pending", n_acc, 2);
    reset           = 1'b1;
    avm_waitrequest = 1'b1;
    exp_addr.delete();
    exp_words.delete();
    step();
    reset           = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_avm_read", avm_read, 0);
    chk("t7_avm_address", avm_address, 0);
    chk("t7_src_valid", src_valid, 0);
    chk("t7_src_sop", src_sop, 0);
    chk("t7_src_eop", src_eop, 0);
    repeat (15) step();
    chk("t7_late_dropped", n_pop, 0);
    chk("t7_no_done", done_cnt, 0);
    chk("t7_fifo_empty", src_valid, 0);

    // Single-word transfer after recovery: sop and eop together.
    step();
    clear_stats();
    lat_fix = 2;
    expect_xfer(15'h0ABC, 15'd1);
    pulse_start(15'h0ABC, 15'd1);
    wait_done(30);
    repeat (3) step();
    chk("t8_words", n_pop, 1);
    chk("t8_done_once", done_cnt, 1);
    chk("sb_drained", exp_words.size() + exp_addr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
